muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle multiply/divide controller sitting beside the execute stage, owning the HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO requests from the execute control path and sequences a 32-iteration shift-add multiplier or restoring divider. While an operation is in flight, it asserts a stall to hold any further HI/LO-dependent instruction in execute. MFHI/MFLO results are returned combinationally for the execute result path.

## Interface
- No parameters; datapath is fixed at 32 bits, with a 64-bit HI:LO result.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_nrst  in  1  reset, synchronous, active-low.
- i_con_mdstart  in  1  request valid in execute this cycle.
- i_con_mdop  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- i_data_rs  in  32  forwarded rs operand: multiplicand/dividend, or MTHI/MTLO data.
- i_data_rt  in  32  forwarded rt operand: multiplier/divisor.
- o_data_hilo  out  32  HI when op=4, LO otherwise; combinational from the registers.
- o_con_busy  out  1  high when the state is not IDLE.
- o_con_stall  out  1  combinational: i_con_mdstart & o_con_busy. All eight ops stall while busy.

## Operation
- **States:** IDLE, MUL, DIV, FIX. A 5-bit iteration counter runs 0..31.
- **Reset:** state IDLE, HI=LO=0, counter 0, and all internal operand registers 0.
  - Output values under reset: o_con_busy=0, o_con_stall=0, o_data_hilo=0.
- **IDLE, request accepted (mdstart & !stall):**
  - **op 0–3:**
    - Latch absolute values of rs and rt; signed ops only, unsigned ops latch raw values.
    - Record the negate-result flag (sign_rs ^ sign_rt) and the negate-remainder flag (sign_rs).
    - Record the divide-by-zero flag (rt==0).
    - Clear the counter; go to MUL (ops 0/1) or DIV (ops 2/3).
  - **op 6/7:** write HI or LO with rs at this edge; stay in IDLE.
  - **op 4/5:** no state change; o_data_hilo is valid this cycle.
- **MUL:**
  - One multiplier bit per cycle into a 64-bit accumulator, LSB first.
  - At counter==31, go to FIX; otherwise increment the counter.
- **DIV:**
  - One restoring step per cycle: shift the remainder left by one and bring in the next dividend bit (MSB first).
  - Trial-subtract the divisor; on no borrow, keep the difference and shift in quotient bit 1, else 0.
  - At counter==31, go to FIX.
- **FIX:**
  - Apply sign correction:
    - Product: 64-bit two's-complement negate if the negate-result flag is set.
    - Quotient: negate if the negate-result flag is set.
    - Remainder: negate if the negate-remainder flag is set.
  - Divide by zero overrides both the restoring result and sign correction: LO=0xFFFFFFFF, HI=original rs.
  - Write HI:LO at this edge; go to IDLE.
- **Signed overflow:** 0x80000000 / −1 gives LO=0x80000000, HI=0. This falls out of magnitude arithmetic; no special case is needed.
- **Stalled requests:** the upstream holds a stalled request unchanged. The module does not latch anything from it.
- **Operand changes while busy:** changes to i_data_rs/i_data_rt have no effect.

## Timing
- Request accepted at the edge ending cycle T.
  - MUL/DIV state occupies cycles T+1..T+32.
  - FIX occupies T+33; HI/LO are written at the edge ending T+33.
  - IDLE resumes at T+34.
- Latency is 33 busy cycles. A HI/LO request presented at T+1..T+33 stalls; at T+34 it proceeds with no stall and sees the new value.
- The issuing MULT/DIV itself never stalls when IDLE. Non-HI/LO instructions never stall.
- MTHI/MTLO: the written value is visible on o_data_hilo from the next cycle. Same-cycle MF after MT is not possible, since they occupy different cycles.
- **Reset asserted mid-operation:** at that edge the sequencer aborts to IDLE and HI=LO=0. busy and stall are low in the following cycle.
- **Reset and request in the same cycle:** reset wins and the request is dropped.

## Test plan
- **Reset:** hold i_nrst=0 for 1 edge, then MFHI and MFLO.
  - Required: o_data_hilo=0x00000000 for both, busy=0, stall=0.
- **MULT −2×3:**
  - Issue rs=0xFFFFFFFE, rt=3 at T, then MFLO from T+1.
  - Required: stall high for T+1..T+33, busy for exactly 33 cycles.
  - Required at T+34: LO=0xFFFFFFFA, HI=0xFFFFFFFF.
- **MULTU:**
  - Issue 0xFFFFFFFF × 0xFFFFFFFF.
  - Required: HI=0xFFFFFFFE, LO=0x00000001.
- **DIV signed cases:**
  - −7/2 (rs=0xFFFFFFF9, rt=2): required LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF: required LO=0x80000000, HI=0x00000000.
- **DIVU 5/0:**
  - Required: LO=0xFFFFFFFF, HI=0x00000005, full 33-cycle busy.
- **Mid-operation and idle writes:**
  - Start DIVU 100/7 and pull i_nrst low at T+10.
    - Required next cycle: busy=0, HI=LO=0.
  - Then MTHI rs=0x00001234 and MTLO rs=0xCAFEF00D.
    - Required on the following MFHI/MFLO: 0x00001234 and 0xCAFEF00D, with no stall.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// HI/LO owner beside execute: sequences a 32-step shift-add multiply or
// restoring divide, applies sign fixup, and serves MFHI/MFLO/MTHI/MTLO.
module muldiv_sequencer (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_con_mdstart,
  input  logic [2:0]  i_con_mdop,
  input  logic [31:0] i_data_rs,
  input  logic [31:0] i_data_rt,
  output logic [31:0] o_data_hilo,
  output logic        o_con_busy,
  output logic        o_con_stall
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state;
  logic [31:0] hi, lo;
  logic [31:0] opa;       // multiplicand for MUL; raw rs for DIV (div-by-zero HI)
  logic [31:0] opb;       // multiplier (shifted right each step) or divisor
  logic [63:0] acc;       // MUL: product; DIV: {remainder, dividend->quotient}
  logic [4:0]  cnt;
  logic        neg_res, neg_rem, div_zero, is_div;

  logic        accept, sgn, sign_rs, sign_rt;
  logic [31:0] abs_rs, abs_rt;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign o_con_busy  = (state != IDLE);
  assign o_con_stall = i_con_mdstart & o_con_busy;
  assign o_data_hilo = (i_con_mdop == 3'd4) ? hi : lo;
  assign accept      = i_con_mdstart & ~o_con_busy;

  always_comb begin
    sgn      = ~i_con_mdop[0];
    sign_rs  = sgn & i_data_rs[31];
    sign_rt  = sgn & i_data_rt[31];
    abs_rs   = sign_rs ? -i_data_rs : i_data_rs;
    abs_rt   = sign_rt ? -i_data_rt : i_data_rt;
    mul_sum  = {1'b0, acc[63:32]} + (opb[0] ? {1'b0, opa} : 33'd0);
    rem_sh   = {acc[63:32], acc[31]};
    // Top bit of diff set means the trial subtract borrowed
    diff     = {1'b0, rem_sh} - {2'b00, opb};
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[31:0] : acc[31:0];
    rem_fix  = neg_rem ? -acc[63:32] : acc[63:32];
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          case (i_con_mdop)
            3'd0, 3'd1: begin
              opa     <= abs_rs;
              opb     <= abs_rt;
              acc     <= '0;
              is_div  <= 1'b0;
              state   <= MUL;
            end
            3'd2, 3'd3: begin
              opa     <= i_data_rs;
              opb     <= abs_rt;
              acc     <= {32'd0, abs_rs};
              is_div  <= 1'b1;
              state   <= DIV;
            end
            3'd6: hi <= i_data_rs;
            3'd7: lo <= i_data_rs;
            default: ;
          endcase
          if (!i_con_mdop[2]) begin
            neg_res  <= sign_rs ^ sign_rt;
            neg_rem  <= sign_rs;
            div_zero <= (i_data_rt == 32'd0);
            cnt      <= '0;
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[31:1]};
          opb <= {1'b0, opb[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        DIV: begin
          acc <= {(diff[33] ? rem_sh[31:0] : diff[31:0]), acc[30:0], ~diff[33]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end else if (div_zero) begin
            hi <= opa;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + random bench for muldiv_sequencer with a HI:LO scoreboard queue.
module tb_muldiv_sequencer;
  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        i_con_mdstart = 1'b0;
  logic [2:0]  i_con_mdop = 3'd0;
  logic [31:0] i_data_rs = '0;
  logic [31:0] i_data_rt = '0;
  logic [31:0] o_data_hilo;
  logic        o_con_busy, o_con_stall;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  muldiv_sequencer dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_con_mdstart(i_con_mdstart),
    .i_con_mdop(i_con_mdop), .i_data_rs(i_data_rs), .i_data_rt(i_data_rt),
    .o_data_hilo(o_data_hilo), .o_con_busy(o_con_busy), .o_con_stall(o_con_stall)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are read 1ns later.
  task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge i_clk);
    i_con_mdstart = st;
    i_con_mdop    = op;
    i_data_rs     = rs;
    i_data_rt     = rt;
    #1;
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic [63:0] r;
    int a, b;
    a = rs;
    b = rt;
    r = '0;
    case (op)
      3'd0: r = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
      3'd1: r = {32'd0, rs} * {32'd0, rt};
      3'd2: begin
        if (rt == 0) r = {rs, 32'hFFFF_FFFF};
        else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(a % b), 32'(a / b)};
      end
      3'd3: begin
        if (rt == 0) r = {rs, 32'hFFFF_FFFF};
        else r = {rs % rt, rs / rt};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issue at T, hammer MFLO (with scrambled operands) through T+33, read at T+34.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int bcnt, scnt;
    logic [63:0] e;
    exp_q.push_back(model(op, rs, rt));
    drive(1'b1, op, rs, rt);
    chk({tag, ":issue_stall"}, 32'(o_con_stall), 32'd0);
    bcnt = 0;
    scnt = 0;
    for (int c = 1; c <= 33; c++) begin
      drive(c != 16, 3'd5, $urandom, $urandom);
      if (o_con_busy)  bcnt++;
      if (o_con_stall) scnt++;
      if (c == 16) chk({tag, ":nohilo_stall"}, 32'(o_con_stall), 32'd0);
    end
    chk({tag, ":busy_cycles"}, 32'(bcnt), 32'd33);
    chk({tag, ":stall_cycles"}, 32'(scnt), 32'd32);
    drive(1'b1, 3'd5, $urandom, $urandom);
    chk({tag, ":busy_done"}, 32'(o_con_busy), 32'd0);
    chk({tag, ":stall_done"}, 32'(o_con_stall), 32'd0);
    e = exp_q.pop_front();
    chk({tag, ":lo"}, o_data_hilo, e[31:0]);
    i_con_mdop = 3'd4;
    #1;
    chk({tag, ":hi"}, o_data_hilo, e[63:32]);
  endtask

  initial begin
    logic [31:0] rs, rt;
    // Reset, with an MTLO presented during reset that must be dropped
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    drive(1'b1, 3'd7, 32'hDEAD_BEEF, 32'd0);
    drive(1'b1, 3'd5, 32'd0, 32'd0);
    i_nrst = 1'b1;
    #1;
    chk("rst:lo", o_data_hilo, 32'd0);
    chk("rst:busy", 32'(o_con_busy), 32'd0);
    chk("rst:stall", 32'(o_con_stall), 32'd0);
    i_con_mdop = 3'd4;
    #1;
    chk("rst:hi", o_data_hilo, 32'd0);

    run_op("mult_m2x3", 3'd0, 32'hFFFF_FFFE, 32'd3);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7d2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_5d0", 3'd3, 32'd5, 32'd0);
    for (int i = 0; i < 4; i++) begin
      for (int op = 0; op < 4; op++) begin
        rs = $urandom;
        rt = $urandom;
        if (op >= 2) rt = rt >> $urandom_range(0, 28);
        run_op($sformatf("rand%0d_op%0d", i, op), 3'(op), rs, rt);
      end
    end
    run_op("divu_5d0_again", 3'd3, 32'd5, 32'd0);

    // Reset during DIVU 100/7 at T+10
    drive(1'b1, 3'd3, 32'd100, 32'd7);
    for (int c = 1; c <= 9; c++) drive(1'b1, 3'd5, 32'd0, 32'd0);
    drive(1'b1, 3'd5, 32'd0, 32'd0);
    i_nrst = 1'b0;
    drive(1'b1, 3'd5, 32'd0, 32'd0);
    i_nrst = 1'b1;
    #1;
    chk("midrst:busy", 32'(o_con_busy), 32'd0);
    chk("midrst:stall", 32'(o_con_stall), 32'd0);
    chk("midrst:lo", o_data_hilo, 32'd0);
    i_con_mdop = 3'd4;
    #1;
    chk("midrst:hi", o_data_hilo, 32'd0);

    // MTHI / MTLO then readback
    drive(1'b1, 3'd6, 32'h0000_1234, 32'd0);
    chk("mthi:stall", 32'(o_con_stall), 32'd0);
    drive(1'b1, 3'd7, 32'hCAFE_F00D, 32'd0);
    chk("mtlo:stall", 32'(o_con_stall), 32'd0);
    chk("mtlo:lo_not_yet", o_data_hilo, 32'd0);
    drive(1'b1, 3'd4, 32'd0, 32'd0);
    chk("mfhi:stall", 32'(o_con_stall), 32'd0);
    chk("mfhi:val", o_data_hilo, 32'h0000_1234);
    i_con_mdop = 3'd5;
    #1;
    chk("mflo:val", o_data_hilo, 32'hCAFE_F00D);
    drive(1'b0, 3'd0, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
